// File: rtl/cable_test_ctrl.sv
// Run-level sequencer for one loopback cable test: launches the generator, counts
// sent/received/mismatched packets, injects at most one error and runs a watchdog.
module cable_test_ctrl #(
  parameter int TIMEOUT_W = 32,
  parameter int ERRCNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_start,
  input  logic                 cmd_abort,
  input  logic [63:0]          cfg_packet_count,
  input  logic [7:0]           cfg_cycles_per_packet,
  input  logic [63:0]          cfg_err_packet,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  output logic                 gen_start,
  output logic                 gen_sim_err,
  output logic [63:0]          gen_packet_count,
  output logic [7:0]           gen_cycles_per_packet,
  input  logic                 gen_busy,
  input  logic                 gen_packet_sent,
  input  logic                 chk_packet_rcvd,
  input  logic                 chk_mismatch,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           result,
  output logic [63:0]          sent_count,
  output logic [63:0]          rcvd_count,
  output logic [ERRCNT_W-1:0]  mismatch_count
);

  // Every cmd_/gen_/chk_ strobe is a single-cycle pulse sampled on the rising clock
  // edge; there is no valid/ready backpressure on any of them.
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, DONE} state_t;

  localparam logic [1:0] RES_PASS     = 2'd0;
  localparam logic [1:0] RES_MISMATCH = 2'd1;
  localparam logic [1:0] RES_TIMEOUT  = 2'd2;
  localparam logic [1:0] RES_ABORT    = 2'd3;

  state_t                state, state_d;
  logic [63:0]           err_packet, err_packet_d;
  logic [TIMEOUT_W-1:0]  timeout, timeout_d, wdog, wdog_d;
  logic [63:0]           pkt_count_d, sent_d, rcvd_d;
  logic [7:0]            cpp_d;
  logic [ERRCNT_W-1:0]   mis_d;
  logic [1:0]            result_d;
  logic                  sim_err_used, sim_err_used_d;
  logic                  gen_start_d, gen_sim_err_d, done_d, expire;

  assign busy = (state != IDLE);

  always_comb begin
    state_d        = state;
    err_packet_d   = err_packet;
    timeout_d      = timeout;
    wdog_d         = wdog;
    pkt_count_d    = gen_packet_count;
    cpp_d          = gen_cycles_per_packet;
    sent_d         = sent_count;
    rcvd_d         = rcvd_count;
    mis_d          = mismatch_count;
    result_d       = result;
    sim_err_used_d = sim_err_used;
    gen_start_d    = 1'b0;
    gen_sim_err_d  = 1'b0;
    done_d         = 1'b0;
    expire         = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_start && !gen_busy) begin
          if (cfg_packet_count == 64'd0 || cfg_cycles_per_packet == 8'd0) begin
            result_d = RES_ABORT;
            done_d   = 1'b1;
          end else begin
            pkt_count_d    = cfg_packet_count;
            cpp_d          = cfg_cycles_per_packet;
            err_packet_d   = cfg_err_packet;
            timeout_d      = cfg_timeout;
            wdog_d         = cfg_timeout;
            sent_d         = 64'd0;
            rcvd_d         = 64'd0;
            mis_d          = '0;
            result_d       = RES_PASS;
            sim_err_used_d = 1'b0;
            gen_start_d    = 1'b1;
            state_d        = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (cmd_abort) begin
          result_d = RES_ABORT;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          if (err_packet == 64'd1) begin
            gen_sim_err_d  = 1'b1;
            sim_err_used_d = 1'b1;
          end
          state_d = RUN;
        end
      end
      RUN, DRAIN: begin
        if (gen_packet_sent) sent_d = sent_count + 64'd1;
        if (chk_packet_rcvd) rcvd_d = rcvd_count + 64'd1;
        if (chk_mismatch && mismatch_count != '1) mis_d = mismatch_count + ERRCNT_W'(1);
        // The injection fires the cycle after the registered count reaches err_packet-1.
        if (!sim_err_used && err_packet >= 64'd2 && sent_count == err_packet - 64'd1) begin
          gen_sim_err_d  = 1'b1;
          sim_err_used_d = 1'b1;
        end
        if (timeout != '0) begin
          if (gen_packet_sent || chk_packet_rcvd) begin
            wdog_d = timeout;
          end else begin
            wdog_d = wdog - TIMEOUT_W'(1);
            expire = (wdog <= TIMEOUT_W'(1));
          end
        end
        if (cmd_abort) begin
          result_d = RES_ABORT;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (expire) begin
          result_d = RES_TIMEOUT;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (state == RUN && sent_count == gen_packet_count && !gen_busy) begin
          state_d = DRAIN;
        end else if (state == DRAIN && rcvd_count == gen_packet_count) begin
          result_d = (mis_d != '0 || rcvd_d != gen_packet_count) ? RES_MISMATCH : RES_PASS;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      err_packet            <= 64'd0;
      timeout               <= '0;
      wdog                  <= '0;
      gen_packet_count      <= 64'd0;
      gen_cycles_per_packet <= 8'd0;
      sent_count            <= 64'd0;
      rcvd_count            <= 64'd0;
      mismatch_count        <= '0;
      result                <= 2'd0;
      sim_err_used          <= 1'b0;
      gen_start             <= 1'b0;
      gen_sim_err           <= 1'b0;
      done                  <= 1'b0;
    end else begin
      state                 <= state_d;
      err_packet            <= err_packet_d;
      timeout               <= timeout_d;
      wdog                  <= wdog_d;
      gen_packet_count      <= pkt_count_d;
      gen_cycles_per_packet <= cpp_d;
      sent_count            <= sent_d;
      rcvd_count            <= rcvd_d;
      mismatch_count        <= mis_d;
      result                <= result_d;
      sim_err_used          <= sim_err_used_d;
      gen_start             <= gen_start_d;
      gen_sim_err           <= gen_sim_err_d;
      done                  <= done_d;
    end
  end

endmodule

// File: doc/cable_test_ctrl.md
Name: cable_test_ctrl

Overview:
Run-level sequencer for one loopback cable test. Latches a test configuration and launches the packet generator. Counts packets sent by the generator and packets received and checked by the loopback checker, optionally schedules a single injected bit error, and runs an inactivity watchdog. Reports a final result code and status counters to the control/status register block.

Parameters:
TIMEOUT_W, 32, width of the watchdog reload value and timer.
ERRCNT_W, 32, width of the saturating mismatch counter.

Ports:
clk  in  1  single clock.
reset  in  1  asynchronous, active-high reset.
cmd_start  in  1  one-cycle pulse that requests a test run.
cmd_abort  in  1  one-cycle pulse that aborts the active run.
cfg_packet_count  in  64  number of packets in the run.
cfg_cycles_per_packet  in  8  data beats per packet.
cfg_err_packet  in  64  1-based packet index that gets an injected error; 0 = no injection.
cfg_timeout  in  TIMEOUT_W  watchdog reload value, in cycles.
gen_start  out  1  one-cycle start pulse to the generator.
gen_sim_err  out  1  one-cycle error-injection pulse to the generator.
gen_packet_count  out  64  latched cfg_packet_count.
gen_cycles_per_packet  out  8  latched cfg_cycles_per_packet.
gen_busy  in  1  generator is active.
gen_packet_sent  in  1  pulse: generator completed one packet.
chk_packet_rcvd  in  1  pulse: checker completed one received packet.
chk_mismatch  in  1  pulse: checker found a data mismatch.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a run ends.
result  out  2  0=pass, 1=mismatch, 2=timeout, 3=abort or bad configuration; held until the next accepted start.
sent_count  out  64  packets sent in the current or last run.
rcvd_count  out  64  packets received in the current or last run.
mismatch_count  out  ERRCNT_W  mismatches in the current or last run; saturates at all-ones.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs and counters = 0; watchdog = 0.
- IDLE:
  - cmd_start is ignored while gen_busy=1.
  - cmd_start with cfg_packet_count=0 or cfg_cycles_per_packet=0: result=3, done pulses the next cycle, state stays IDLE.
  - Otherwise: latch all cfg_* inputs; clear the three counters and result; load watchdog=cfg_timeout; assert gen_start for exactly one cycle (the cycle after cmd_start); go to LAUNCH.
- LAUNCH (1 cycle):
  - If latched err_packet=1, pulse gen_sim_err.
  - Go to RUN.
- RUN:
  - gen_packet_sent increments sent_count.
  - chk_packet_rcvd increments rcvd_count.
  - chk_mismatch increments mismatch_count, saturating.
  - Simultaneous pulses are all counted in the same cycle.
  - When gen_packet_sent makes sent_count = err_packet-1 (err_packet>=2), pulse gen_sim_err on the next cycle. At most one gen_sim_err pulse per run.
  - When sent_count = packet_count and gen_busy=0, go to DRAIN.
- DRAIN:
  - Counting continues.
  - When rcvd_count = packet_count, go to DONE.
  - Extra receive pulses beyond packet_count are still counted.
- Watchdog (RUN and DRAIN):
  - Reloads to cfg_timeout on any gen_packet_sent or chk_packet_rcvd pulse; otherwise decrements each cycle.
  - On reaching 0: result=2, go to DONE.
  - A latched cfg_timeout of 0 disables the watchdog.
- cmd_abort in LAUNCH, RUN or DRAIN: result=3, go to DONE.
- Priority within one cycle: abort > timeout > normal completion.
- DONE (1 cycle):
  - done=1.
  - If result is still unset (no abort or timeout), result = 1 when mismatch_count≠0 or rcvd_count≠packet_count, else 0.
  - Go to IDLE.
- Counters and result hold their values in IDLE until the next accepted start.
- Counter width rules: sent_count and rcvd_count are 64-bit and wrap; mismatch_count saturates.
- Latency: cmd_start to gen_start = 1 cycle. Final count event to done = 2 cycles (DRAIN detect, then DONE).
- An aborted generator may keep running. A new start is refused until gen_busy falls.

Test Plan:
- Clean run: count=4, cpp=8, err=0, timeout=1000; model gen and checker loop back 4 packets -> gen_start single pulse, sent=rcvd=4, mismatch=0, done pulse, result=0.
- Injection: count=5, err=3; checker flags a mismatch on packet 3 -> exactly one gen_sim_err pulse, the cycle after sent_count becomes 2; mismatch=1, result=1.
- Lost packet: count=3; checker returns only 2 packets, timeout=50 -> done exactly 50 cycles after the last rcvd pulse, result=2, rcvd=2.
- Abort in RUN after 1 packet, landing in the same cycle as a watchdog expiry -> result=3, done next cycle. cmd_start while gen_busy=1 is ignored (no gen_start).
- Bad configuration: count=0 -> no gen_start, done pulse, result=3. Then cpp=0 -> same response.
- Reset asserted mid-DRAIN -> busy, done, counters and outputs = 0 immediately (asynchronous). A following clean run passes.
